prog_loader: RTL and testbench
==============================

# prog_loader

Byte-stream program loader that sits directly upstream of `top_level`. It drives the instruction-memory write port (`W`, `ADDR`, `DATA_WR`) and holds the CPU in reset while loading. It accepts a framed byte stream over a valid/ready handshake, assembles big-endian instruction words and writes them to consecutive addresses from 0. It releases the CPU only after a complete, and optionally checksum-verified, image is in memory.

## Interface
- `DATA_SIZE`, 16, instruction word width in bits; must be a multiple of 8. Bytes per word `BPW = DATA_SIZE/8`.
- `ADDR_SIZE`, 5, memory address width; must be ≤ 8. Maximum image size is `2**ADDR_SIZE` words.

Ports:
- `clk`  in  1  single clock; all logic is on the posedge.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle load request; honoured only in IDLE, DONE or ERR.
- `in_valid`  in  1  a byte is present on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `W`  out  1  memory write strobe, one cycle per word.
- `ADDR`  out  ADDR_SIZE  memory write address.
- `DATA_WR`  out  DATA_SIZE  memory write data.
- `cpu_rstn`  out  1  active-low reset to `top_level`.
- `busy`  out  1  load in progress.
- `done`  out  1  image loaded successfully; level output.
- `error`  out  1  framing or checksum failure; level output.

## Operation
- Frame format: one COUNT byte N, then N×BPW data bytes, high byte of each word first. With `PROG_LOADER_CHECKSUM_EN`, one extra CHK byte follows the data.
- A transfer occurs on a posedge where `in_valid && in_ready`.
- States and transitions:
  - IDLE: `start` → COUNT.
  - COUNT: byte accepted; N==0 or N>2**ADDR_SIZE → ERR, otherwise → DATA with word index 0.
  - DATA: collects BPW bytes; after the last byte of a word → WRITE.
  - WRITE: asserts `W` for exactly one cycle with `ADDR`=index and `DATA_WR`=assembled word. If more words remain, index+1 → DATA. After the last word → CHECK when the macro is defined, otherwise → DONE.
  - CHECK: CHK byte accepted; CHK equal to the XOR of all data bytes → DONE, otherwise → ERR.
  - DONE: `done`=1, `cpu_rstn`=1; `start` → COUNT.
  - ERR: `error`=1, `cpu_rstn`=0; `start` → COUNT.
- `in_ready`=1 only in COUNT, DATA and CHECK; 0 in IDLE, WRITE, DONE and ERR.
- `busy`=1 in COUNT, DATA, WRITE and CHECK.
- `cpu_rstn`=1 only in DONE. It drops to 0 in the cycle after an accepted `start`, so the CPU is held in reset for the whole load.
- `start` is ignored while `busy`. `in_valid` is ignored outside the accepting states, so bytes presented there are not consumed.
- The index never wraps: the COUNT check guarantees the final index is ≤ 2**ADDR_SIZE−1.
- `done` and `error` clear on the cycle after an accepted `start`.
- The XOR accumulator and the byte counter clear on entry to COUNT.

## Timing
- Reset values: state IDLE, `in_ready`=0, `W`=0, `ADDR`=0, `DATA_WR`=0, `cpu_rstn`=0, `busy`=0, `done`=0, `error`=0.
- `rstn` asserted mid-load aborts immediately. Memory content written before the abort is left as is.
- All outputs are registered.
- `ADDR` and `DATA_WR` hold their last written value outside WRITE.
- Latency: the last byte of a word is accepted at edge k; `W`=1 during cycle k+1; the next byte is accepted at edge k+2 at the earliest.
- Peak throughput is 1 word per BPW+1 cycles.
- `done`/`cpu_rstn` rise one cycle after the final WRITE (no checksum) or after CHK acceptance (checksum enabled).
- `in_valid` gaps (stalls) of any length are legal in every accepting state.

## Configuration
- `PROG_LOADER_CHECKSUM_EN` defined:
  - CHECK state exists and the frame carries the trailing CHK byte.
  - A CHK mismatch → ERR with the CPU kept in reset.
- Not defined:
  - No CHK byte and no accumulator.
  - WRITE of the last word → DONE directly.

## Test plan
- Checksum enabled; `start`, then 0x02, 0x12, 0x34, 0xAB, 0xCD, 0x40 → `W` pulses at ADDR 0 with DATA_WR 0x1234 and at ADDR 1 with 0xABCD; `done`=1, `cpu_rstn`=1, `error`=0.
- Same frame with CHK 0x41 → both writes still occur; `error`=1, `done`=0, `cpu_rstn`=0.
- COUNT 0x00, then separately COUNT 0x21 with ADDR_SIZE=5 → ERR immediately, no `W` pulse; a following `start` clears `error`.
- Full image: COUNT 0x20, words 0x0000..0x001F, with `in_valid` randomly deasserted 0–3 cycles → 32 writes at ADDR 0..31, each `W` exactly one cycle, `done`=1.
- `rstn` pulsed low after 3 of 4 bytes for N=2 → all outputs return to reset values at once; a new frame then loads from ADDR 0.
- `start` asserted mid-load → ignored (no restart, `done` follows the original frame). `start` in DONE → `cpu_rstn` falls the next cycle and `busy`=1.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream loader that writes big-endian words to instruction memory and holds the CPU in reset until done.
// Optional trailing XOR checksum byte enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int DATA_SIZE = 16,
  parameter int ADDR_SIZE = 5
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 W,
  output logic [ADDR_SIZE-1:0] ADDR,
  output logic [DATA_SIZE-1:0] DATA_WR,
  output logic                 cpu_rstn,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);
  localparam int BPW = DATA_SIZE / 8;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
  typedef enum logic [2:0] {IDLE, COUNT, DATA, WRITE, CHECK, DONE, ERR} state_t;
  state_t state_q, state_d;
  logic [ADDR_SIZE-1:0] idx_q, idx_d, last_q, last_d, addr_q, addr_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic [DATA_SIZE-1:0] word_q, word_d, data_wr_q, data_wr_d;
  logic in_ready_q, in_ready_d, w_q, w_d, cpu_rstn_q, cpu_rstn_d;
  logic busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic fire, bad_count, last_byte;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] xor_q, xor_d;
`endif
  assign fire = in_valid && in_ready_q;
  assign bad_count = (in_data == 8'd0) || ({1'b0, in_data} > 9'(2 ** ADDR_SIZE));
  assign last_byte = bcnt_q == BCW'(BPW - 1);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      last_q     <= '0;
      bcnt_q     <= '0;
      word_q     <= '0;
      in_ready_q <= 1'b0;
      w_q        <= 1'b0;
      addr_q     <= '0;
      data_wr_q  <= '0;
      cpu_rstn_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      bcnt_q     <= bcnt_d;
      word_q     <= word_d;
      in_ready_q <= in_ready_d;
      w_q        <= w_d;
      addr_q     <= addr_d;
      data_wr_q  <= data_wr_d;
      cpu_rstn_q <= cpu_rstn_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    xor_d   = xor_q;
`endif
    case (state_q)
      COUNT: if (fire) begin
        state_d = bad_count ? ERR : DATA;
        idx_d   = '0;
        last_d  = ADDR_SIZE'(in_data - 8'd1);
      end
      DATA: if (fire) begin
        word_d  = DATA_SIZE'({word_q, in_data});
        bcnt_d  = last_byte ? '0 : bcnt_q + 1'b1;
        state_d = last_byte ? WRITE : DATA;
`ifdef PROG_LOADER_CHECKSUM_EN
        xor_d   = xor_q ^ in_data;
`endif
      end
      WRITE: begin
        idx_d = (idx_q == last_q) ? idx_q : idx_q + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
        state_d = (idx_q == last_q) ? CHECK : DATA;
`else
        state_d = (idx_q == last_q) ? DONE : DATA;
`endif
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CHECK: if (fire) state_d = (in_data == xor_q) ? DONE : ERR;
`endif
      default: ;
    endcase
    // start restarts only from the idle/terminal states; counters clear on entry to COUNT
    if ((state_q == IDLE || state_q == DONE || state_q == ERR) && start) begin
      state_d = COUNT;
      bcnt_d  = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      xor_d   = '0;
`endif
    end
  end
  always_comb begin
    in_ready_d = state_d == COUNT || state_d == DATA || state_d == CHECK;
    busy_d     = state_d == COUNT || state_d == DATA || state_d == WRITE || state_d == CHECK;
    done_d     = state_d == DONE;
    error_d    = state_d == ERR;
    cpu_rstn_d = state_d == DONE;
    w_d        = state_d == WRITE;
    addr_d     = w_d ? idx_d : addr_q;
    data_wr_d  = w_d ? word_d : data_wr_q;
  end
  assign in_ready = in_ready_q;
  assign W        = w_q;
  assign ADDR     = addr_q;
  assign DATA_WR  = data_wr_q;
  assign cpu_rstn = cpu_rstn_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed bench for prog_loader; sends the CHK byte only when PROG_LOADER_CHECKSUM_EN is defined.
module tb_prog_loader;
  logic clk = 1'b0, rstn, start, in_valid;
  logic [7:0] in_data;
  logic in_ready, W, cpu_rstn, busy, done, error;
  logic [4:0] ADDR;
  logic [15:0] DATA_WR;
  int checks = 0, errors = 0, w_double = 0;
  logic w_prev = 1'b0;
  logic [4:0] wa[$];
  logic [15:0] wd[$];

  prog_loader dut (.clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .W(W), .ADDR(ADDR), .DATA_WR(DATA_WR), .cpu_rstn(cpu_rstn),
    .busy(busy), .done(done), .error(error));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (W) begin
      wa.push_back(ADDR);
      wd.push_back(DATA_WR);
    end
    if (W && w_prev) w_double++;
    w_prev = W;
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data = b;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      errors++;
      $display("FAIL send_timeout byte=%h got in_ready=%b want 1", b, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end;
    int n = 0;
    while (!done && !error && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    checks++; if (W !== 1'b0) begin errors++; $display("FAIL rst_w got %b want 0", W); end
    checks++; if (ADDR !== 5'd0) begin errors++; $display("FAIL rst_addr got %h want 0", ADDR); end
    checks++; if (DATA_WR !== 16'd0) begin errors++; $display("FAIL rst_data got %h want 0", DATA_WR); end
    checks++; if ({cpu_rstn, busy, done, error} !== 4'b0000) begin errors++; $display("FAIL rst_flags got %b want 0000", {cpu_rstn, busy, done, error}); end
  endtask

  task automatic test_load_ok;
    wa.delete(); wd.delete();
    pulse_start();
    checks++; if ({busy, cpu_rstn} !== 2'b10) begin errors++; $display("FAIL ok_start busy/cpu_rstn got %b want 10", {busy, cpu_rstn}); end
    send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    checks++; if ({W, ADDR, DATA_WR} !== {1'b1, 5'd0, 16'h1234}) begin errors++; $display("FAIL ok_latency got W=%b A=%h D=%h want 1 00 1234", W, ADDR, DATA_WR); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ok_ready_in_write got %b want 0", in_ready); end
    send_byte(8'hAB); send_byte(8'hCD);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'h40);
`endif
    wait_end();
    checks++; if ({done, error, cpu_rstn, busy, in_ready} !== 5'b10100) begin errors++; $display("FAIL ok_final got %b want 10100", {done, error, cpu_rstn, busy, in_ready}); end
    checks++; if (wa.size() !== 2) begin errors++; $display("FAIL ok_nwrites got %0d want 2", wa.size()); end
    else begin
      checks++; if ({wa[0], wd[0], wa[1], wd[1]} !== {5'd0, 16'h1234, 5'd1, 16'hABCD}) begin errors++; $display("FAIL ok_writes got %h:%h %h:%h want 00:1234 01:abcd", wa[0], wd[0], wa[1], wd[1]); end
    end
    checks++; if ({ADDR, DATA_WR} !== {5'd1, 16'hABCD}) begin errors++; $display("FAIL ok_hold got %h %h want 01 abcd", ADDR, DATA_WR); end
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_bad_chk;
    wa.delete(); wd.delete();
    pulse_start();
    send_byte(8'h02); send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h41);
    wait_end();
    checks++; if ({error, done, cpu_rstn} !== 3'b100) begin errors++; $display("FAIL chk_flags got %b want 100", {error, done, cpu_rstn}); end
    checks++; if (wa.size() !== 2) begin errors++; $display("FAIL chk_nwrites got %0d want 2", wa.size()); end
  endtask
`endif

  task automatic test_bad_count;
    wa.delete(); wd.delete();
    pulse_start();
    send_byte(8'h00);
    checks++; if ({error, busy, cpu_rstn, in_ready} !== 4'b1000) begin errors++; $display("FAIL cnt0_flags got %b want 1000", {error, busy, cpu_rstn, in_ready}); end
    pulse_start();
    checks++; if ({error, busy} !== 2'b01) begin errors++; $display("FAIL cnt_restart got %b want 01", {error, busy}); end
    send_byte(8'h21);
    checks++; if ({error, busy, done} !== 3'b100) begin errors++; $display("FAIL cnt21_flags got %b want 100", {error, busy, done}); end
    checks++; if (wa.size() !== 0) begin errors++; $display("FAIL cnt_nwrites got %0d want 0", wa.size()); end
  endtask

  task automatic test_full_image;
    int bad = 0;
    wa.delete(); wd.delete(); w_double = 0;
    pulse_start();
    send_byte(8'h20);
    for (int i = 0; i < 32; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_byte(8'h00);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_byte(8'(i));
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    wait_end();
    checks++; if ({done, error, cpu_rstn} !== 3'b101) begin errors++; $display("FAIL full_flags got %b want 101", {done, error, cpu_rstn}); end
    checks++; if (wa.size() !== 32) begin errors++; $display("FAIL full_nwrites got %0d want 32", wa.size()); end
    else begin
      for (int i = 0; i < 32; i++) if (wa[i] !== 5'(i) || wd[i] !== 16'(i)) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL full_writes got %0d bad entries want 0", bad); end
    end
    checks++; if (w_double !== 0) begin errors++; $display("FAIL full_wpulse got %0d multi-cycle W want 0", w_double); end
  endtask

  task automatic test_reset_mid;
    wa.delete(); wd.delete();
    pulse_start();
    send_byte(8'h02); send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB);
    #2 rstn = 1'b0;
    #1;
    checks++; if ({in_ready, W, ADDR, DATA_WR, cpu_rstn, busy, done, error} !== 27'd0) begin errors++; $display("FAIL mid_reset got rdy=%b W=%b A=%h D=%h flags=%b want all 0", in_ready, W, ADDR, DATA_WR, {cpu_rstn, busy, done, error}); end
    @(negedge clk); rstn = 1'b1; @(negedge clk);
    wa.delete(); wd.delete();
    pulse_start();
    send_byte(8'h01); send_byte(8'h55); send_byte(8'h66);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'h33);
`endif
    wait_end();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mid_reload_done got %b want 1", done); end
    checks++; if (wa.size() !== 1 || wa[0] !== 5'd0 || wd[0] !== 16'h5566) begin errors++; $display("FAIL mid_reload_write got n=%0d want 1 write 00:5566", wa.size()); end
  endtask

  task automatic test_start_midload;
    wa.delete(); wd.delete();
    pulse_start();
    send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midstart_busy got %b want 1", busy); end
    send_byte(8'h33); send_byte(8'h44);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'h44);
`endif
    wait_end();
    checks++; if ({done, error} !== 2'b10) begin errors++; $display("FAIL midstart_done got %b want 10", {done, error}); end
    checks++; if (wa.size() !== 2 || wd[0] !== 16'h1122 || wd[1] !== 16'h3344) begin errors++; $display("FAIL midstart_writes got n=%0d want 2 writes 1122 3344", wa.size()); end
    pulse_start();
    checks++; if ({cpu_rstn, busy, done} !== 3'b010) begin errors++; $display("FAIL done_restart got %b want 010", {cpu_rstn, busy, done}); end
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    test_reset();
    rstn = 1'b1;
    @(negedge clk);
    test_load_ok();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_bad_chk();
`endif
    test_bad_count();
    test_full_image();
    test_reset_mid();
    test_start_midload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
